icache_fetch: RTL
=================

Name: icache_fetch

Overview:
- Direct-mapped, read-only instruction cache directly upstream of the fetch stage; replaces the combinational instruction ROM read.
- Looks up PCF in the same cycle and returns InstrF on a hit.
- On a miss, raises ICacheStall (OR'd into StallFetch/StallDecode by the hazard unit) and refills one line from backing memory over a word-serial handshake.
- Supports whole-cache invalidate for fence.i.

Parameters:
- NUM_SETS, 64, number of lines; power of two.
- WORDS_PER_LINE, 4, 32-bit words per line; power of two, at least 2.
- Derived: TAG_W = 32 - log2(NUM_SETS) - log2(WORDS_PER_LINE) - 2. Defaults: tag 22, index 6, word 2, byte 2.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-low reset (sampled on clk, 0 = reset).
- PCF  in  32  fetch address; bits [1:0] ignored.
- ReqF  in  1  fetch request valid this cycle.
- Flush  in  1  invalidate all lines (one-cycle pulse).
- InstrF  out  32  instruction word; valid when ICacheStall=0 and ReqF=1.
- ICacheStall  out  1  miss or refill in progress.
- MemReq  out  1  line refill request, level-held.
- MemAddr  out  32  line-aligned refill base address.
- MemRdata  in  32  refill word.
- MemRvalid  in  1  refill beat valid; one word per beat, ascending order.

Behaviour:
- Reset (rst=0 at edge):
  - Valid bits all 0; FSM to IDLE; word counter 0; flush-pending flag 0.
  - MemReq=0 from the next cycle; MemAddr=0.
  - Reset mid-refill aborts the refill; the partially written line stays invalid.
- Lookup is combinational: hit = ReqF & valid[idx] & (tag[idx]==PCF tag).
- InstrF:
  - On a hit in IDLE: data[idx][word].
  - Otherwise: NOP 32'h00000013.
- ICacheStall:
  - 1 when ReqF & ~hit in IDLE.
  - 1 for every cycle in REFILL.
  - 0 otherwise.
- FSM IDLE:
  - On a miss: latch line address {PCF[31:log2(WPL)+2], zeros} into MemAddr, set MemReq=1 next edge, go to REFILL.
  - Flush in IDLE clears all valid bits at the edge.
- FSM REFILL:
  - MemReq held 1; PCF changes ignored.
  - Each MemRvalid beat writes MemRdata into data[latched idx][counter] and increments the counter.
  - On the beat where counter==WPL-1: write tag, set valid (unless flush pending), clear counter, MemReq=0, go to IDLE.
  - The next cycle re-looks up PCF and hits.
  - Flush during REFILL sets flush-pending. At completion, all valid bits are cleared, including the just-filled line; the pending flag then clears.
  - Flush on the final beat counts as pending.
- Miss penalty = memory latency + WPL beats + 1 re-lookup cycle. No critical-word forwarding.
- MemRvalid while in IDLE or MemReq=0 is ignored; no array or counter change.
- Counter width is log2(WPL); it never wraps mid-line because the exit happens at WPL-1.
- A simultaneous miss and Flush in IDLE: the flush applies at the edge and the refill starts. The refilled line is valid (the flush preceded the fill).

Decomposition:
- Package icache_pkg:
  - state enum {IDLE, REFILL};
  - NOP_INSTR constant;
  - localparam functions for TAG_W / index / offset widths.
- Sub-module icache_array holds tag, valid and data storage:
  - one combinational read port;
  - one synchronous word-write port;
  - tag/valid set and global valid-clear inputs.
- icache_fetch holds the FSM, counter, flush-pending flag and address slicing.

Test Plan:
- Cold miss:
  - Stimulus: reset, then PCF=0x0, ReqF=1; memory returns 0x11,0x22,0x33,0x44 after 2-cycle latency.
  - Required: MemReq=1, MemAddr=0x0; ICacheStall high through the last beat. Next cycle InstrF=0x11, stall 0. Then PCF=0x8 gives InstrF=0x33 in the same cycle with no MemReq.
- Conflict:
  - Stimulus: after the cold fill, PCF=0x400 (index 0, different tag).
  - Required: miss with MemAddr=0x400. Returning to PCF=0x0 misses again with MemAddr=0x0.
- Flush during refill:
  - Stimulus: pulse Flush on beat 2 of the fill for 0x0.
  - Required: refill completes and MemReq drops; re-lookup of 0x0 misses again. Flush while IDLE with a valid line: the next access misses.
- Reset mid-refill:
  - Stimulus: rst=0 after 2 beats.
  - Required: MemReq=0 next cycle; line 0 invalid. A fresh request issues MemAddr=0x0 and refills from word 0 correctly.
- Spurious beat:
  - Stimulus: MemRvalid=1, MemRdata=0xDEAD while IDLE with line 0 valid.
  - Required: PCF=0x0 still returns 0x11.
- Idle request:
  - Stimulus: ReqF=0 with any PCF.
  - Required: ICacheStall=0, InstrF=0x00000013, MemReq=0.

Source files
------------

// File: rtl/icache_pkg.sv
// Shared types and width helpers for the direct-mapped instruction cache.
package icache_pkg;

    typedef enum logic {
        IDLE,
        REFILL
    } state_e;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    function automatic int idx_w(input int sets);
        return $clog2(sets);
    endfunction

    function automatic int off_w(input int wpl);
        return $clog2(wpl);
    endfunction

    function automatic int tag_w(input int sets, input int wpl);
        return 32 - $clog2(sets) - $clog2(wpl) - 2;
    endfunction

endpackage

// File: rtl/icache_array.sv
// Tag, valid and data storage: one combinational read port,
// one word-write port, line fill (tag/valid) and global valid clear.
import icache_pkg::*;

module icache_array #(
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 4,
    parameter int IDX_W          = idx_w(NUM_SETS),
    parameter int OFF_W          = off_w(WORDS_PER_LINE),
    parameter int TAG_W          = tag_w(NUM_SETS, WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] i_rd_idx,
    input  logic [OFF_W-1:0] i_rd_word,
    output logic [31:0]      o_rd_data,
    output logic [TAG_W-1:0] o_rd_tag,
    output logic             o_rd_valid,
    input  logic             i_wr_en,
    input  logic [IDX_W-1:0] i_wr_idx,
    input  logic [OFF_W-1:0] i_wr_word,
    input  logic [31:0]      i_wr_data,
    input  logic             i_fill_en,
    input  logic [TAG_W-1:0] i_fill_tag,
    input  logic             i_fill_valid,
    input  logic             i_clr_all
);

    logic [31:0]         r_data  [NUM_SETS*WORDS_PER_LINE];
    logic [TAG_W-1:0]    r_tag   [NUM_SETS];
    logic [NUM_SETS-1:0] r_valid;

    assign o_rd_data  = r_data[{i_rd_idx, i_rd_word}];
    assign o_rd_tag   = r_tag[i_rd_idx];
    assign o_rd_valid = r_valid[i_rd_idx];

    always_ff @(posedge clk) begin
        if (i_wr_en)
            r_data[{i_wr_idx, i_wr_word}] <= i_wr_data;
        if (i_fill_en)
            r_tag[i_wr_idx] <= i_fill_tag;
    end

    // A clear wins over a same-edge fill so a pending flush drops the new line.
    always_ff @(posedge clk) begin
        if (!rst)
            r_valid <= '0;
        else if (i_clr_all)
            r_valid <= '0;
        else if (i_fill_en && i_fill_valid)
            r_valid[i_wr_idx] <= 1'b1;
    end

endmodule

// File: rtl/icache_fetch.sv
// Direct-mapped read-only I-cache in front of fetch: same-cycle lookup,
// word-serial line refill on a miss, whole-cache invalidate for fence.i.
import icache_pkg::*;

module icache_fetch #(
    parameter int NUM_SETS       = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] PCF,
    input  logic        ReqF,
    input  logic        Flush,
    output logic [31:0] InstrF,
    output logic        ICacheStall,
    output logic        MemReq,
    output logic [31:0] MemAddr,
    input  logic [31:0] MemRdata,
    input  logic        MemRvalid
);

    localparam int IDX_W = idx_w(NUM_SETS);
    localparam int OFF_W = off_w(WORDS_PER_LINE);
    localparam int TAG_W = tag_w(NUM_SETS, WORDS_PER_LINE);
    localparam int LSB   = OFF_W + 2;
    localparam logic [31:0] LINE_MASK =
        ~(32'(WORDS_PER_LINE * 4) - 32'd1);
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS_PER_LINE - 1);

    state_e           r_state;
    state_e           w_state_n;
    logic [OFF_W-1:0] r_cnt;
    logic             r_flush_pend;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;
    logic [IDX_W-1:0] r_fill_idx;
    logic [TAG_W-1:0] r_fill_tag;

    logic [TAG_W-1:0] w_tag;
    logic [IDX_W-1:0] w_idx;
    logic [OFF_W-1:0] w_word;
    logic [31:0]      w_rd_data;
    logic [TAG_W-1:0] w_rd_tag;
    logic             w_rd_valid;
    logic             w_hit;
    logic             w_wr_en;
    logic             w_last;
    logic             w_fill_en;
    logic             w_fill_valid;
    logic             w_clr_all;

    assign w_tag  = PCF[31 -: TAG_W];
    assign w_idx  = PCF[LSB +: IDX_W];
    assign w_word = PCF[2 +: OFF_W];
    assign w_hit  = ReqF & w_rd_valid & (w_rd_tag == w_tag);

    assign MemReq  = r_mem_req;
    assign MemAddr = r_mem_addr;

    icache_array #(
        .NUM_SETS       (NUM_SETS),
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_array (
        .clk          (clk),
        .rst          (rst),
        .i_rd_idx     (w_idx),
        .i_rd_word    (w_word),
        .o_rd_data    (w_rd_data),
        .o_rd_tag     (w_rd_tag),
        .o_rd_valid   (w_rd_valid),
        .i_wr_en      (w_wr_en),
        .i_wr_idx     (r_fill_idx),
        .i_wr_word    (r_cnt),
        .i_wr_data    (MemRdata),
        .i_fill_en    (w_fill_en),
        .i_fill_tag   (r_fill_tag),
        .i_fill_valid (w_fill_valid),
        .i_clr_all    (w_clr_all)
    );

    always_comb begin
        w_state_n    = r_state;
        InstrF       = NOP_INSTR;
        ICacheStall  = 1'b0;
        w_wr_en      = 1'b0;
        w_last       = 1'b0;
        w_fill_en    = 1'b0;
        w_fill_valid = 1'b0;
        w_clr_all    = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_clr_all = Flush;
                if (w_hit) begin
                    InstrF = w_rd_data;
                end else if (ReqF) begin
                    ICacheStall = 1'b1;
                    w_state_n   = REFILL;
                end
            end
            REFILL: begin
                ICacheStall = 1'b1;
                if (MemRvalid) begin
                    w_wr_en = 1'b1;
                    if (r_cnt == LAST) begin
                        // A flush seen at any point of the fill kills the line.
                        w_last       = 1'b1;
                        w_fill_en    = 1'b1;
                        w_fill_valid = ~(r_flush_pend | Flush);
                        w_clr_all    = r_flush_pend | Flush;
                        w_state_n    = IDLE;
                    end
                end
            end
            default: w_state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_cnt        <= '0;
            r_flush_pend <= 1'b0;
            r_mem_req    <= 1'b0;
            r_mem_addr   <= '0;
            r_fill_idx   <= '0;
            r_fill_tag   <= '0;
        end else begin
            r_state <= w_state_n;
            if (r_state == IDLE && w_state_n == REFILL) begin
                r_mem_req  <= 1'b1;
                r_mem_addr <= PCF & LINE_MASK;
                r_fill_idx <= w_idx;
                r_fill_tag <= w_tag;
            end
            if (w_wr_en)
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            if (w_last) begin
                r_mem_req    <= 1'b0;
                r_flush_pend <= 1'b0;
            end else if (r_state == REFILL && Flush) begin
                r_flush_pend <= 1'b1;
            end
        end
    end

endmodule
